// File: rtl/swerv_trace_pkg.sv
// Shared types for the SweRV instruction-trace capture stage.
// The entry layout is packed so the FIFO can store it as a single word.
package swerv_trace_pkg;

    localparam int TRACE_SLOTS = 2;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] addr;
        logic        exc;
        logic        intr;
        logic [4:0]  ecause;
        logic        lost;
    } trace_entry_t;

    // The cause field is only meaningful on exception/interrupt slots, so it is zeroed otherwise.
    function automatic trace_entry_t make_entry(
        input logic [31:0] insn,
        input logic [31:0] addr,
        input logic        exc,
        input logic        intr,
        input logic [4:0]  ecause
    );
        trace_entry_t e;
        e.insn   = insn;
        e.addr   = addr;
        e.exc    = exc;
        e.intr   = intr;
        e.ecause = (exc || intr) ? ecause : 5'd0;
        e.lost   = 1'b0;
        return e;
    endfunction

endpackage

// File: rtl/swerv_trace_capture_if.sv
// Valid/ready trace stream from the capture stage to the debug/trace sink.
// The master drives one entry per cycle; the slave accepts it with tr_ready.
interface swerv_trace_capture_if;

    logic        tr_valid;
    logic        tr_ready;
    logic [31:0] tr_insn;
    logic [31:0] tr_addr;
    logic        tr_exc;
    logic        tr_intr;
    logic [4:0]  tr_ecause;
    logic        tr_lost;

    modport master (
        output tr_valid, tr_insn, tr_addr, tr_exc, tr_intr, tr_ecause, tr_lost,
        input  tr_ready
    );

    modport slave (
        input  tr_valid, tr_insn, tr_addr, tr_exc, tr_intr, tr_ecause, tr_lost,
        output tr_ready
    );

endinterface

// File: rtl/swerv_trace_fifo2w1r.sv
// Trace-entry FIFO with two write ports and one read port.
// Port 1 is only written together with port 0 and lands at wr_ptr+1.
module swerv_trace_fifo2w1r
    import swerv_trace_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             wr_en0,
    input  trace_entry_t     wr_data0,
    input  logic             wr_en1,
    input  trace_entry_t     wr_data1,
    input  logic             rd_en,
    output trace_entry_t     rd_data,
    output logic [CNT_W-1:0] count
);

    trace_entry_t     mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [PTR_W-1:0] wr_ptr_p1;
    logic [1:0]       n_wr;
    logic [DEPTH-1:0] we0;
    logic [DEPTH-1:0] we1;

    assign wr_ptr_p1 = wr_ptr_reg + PTR_W'(1);
    assign n_wr      = {1'b0, wr_en0} + {1'b0, wr_en1};

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wdec
            assign we0[gi] = wr_en0 && (wr_ptr_reg == PTR_W'(gi));
            assign we1[gi] = wr_en1 && (wr_ptr_p1 == PTR_W'(gi));
        end
    endgenerate

    // Storage carries no reset; occupancy tracking alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we0[i]) begin
                mem_reg[i] <= wr_data0;
            end else if (we1[i]) begin
                mem_reg[i] <= wr_data1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(n_wr);
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(rd_en);
            count_reg  <= count_reg + CNT_W'(n_wr) - CNT_W'(rd_en);
        end
    end

    assign rd_data = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/swerv_trace_capture.sv
// Trace capture stage: packs up to two retired-instruction slots per cycle into a FIFO,
// drains one per cycle, counts overflow drops. Optional address filter: SWERV_TRACE_FILTER_EN.
module swerv_trace_capture
    import swerv_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int OVF_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     trace_en,
    input  logic [63:0]              trace_rv_i_insn_ip,
    input  logic [63:0]              trace_rv_i_address_ip,
    input  logic [2:0]               trace_rv_i_valid_ip,
    input  logic [2:0]               trace_rv_i_exception_ip,
    input  logic [2:0]               trace_rv_i_interrupt_ip,
    input  logic [4:0]               trace_rv_i_ecause_ip,
`ifdef SWERV_TRACE_FILTER_EN
    input  logic [31:0]              filt_lo,
    input  logic [31:0]              filt_hi,
`endif
    swerv_trace_capture_if.master    tr,
    output logic [OVF_W-1:0]         ovf_cnt,
    input  logic                     ovf_clr,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int CNT_W     = $clog2(DEPTH) + 1;
    localparam int OVF_SUM_W = OVF_W + 1;

    trace_entry_t               slot_entry [TRACE_SLOTS];
    logic [TRACE_SLOTS-1:0]     slot_keep;
    logic [TRACE_SLOTS-1:0]     slot_cand;
    logic [CNT_W-1:0]           fifo_count;
    logic [CNT_W-1:0]           free_slots;
    logic [1:0]                 n_cand;
    logic [1:0]                 n_wr;
    logic [1:0]                 n_drop;
    trace_entry_t               wr_data0;
    trace_entry_t               rd_data;
    trace_entry_t               head;
    logic                       wr_en0;
    logic                       wr_en1;
    logic                       pop;
    logic                       lost_pend_reg;
    logic                       lost_pend_next;
    logic [OVF_W-1:0]           ovf_cnt_reg;
    logic [OVF_W-1:0]           ovf_cnt_next;
    logic [OVF_SUM_W-1:0]       ovf_sum;
    logic                       unused_bits;

    assign unused_bits = ^{trace_rv_i_valid_ip[2], trace_rv_i_exception_ip[2],
                           trace_rv_i_interrupt_ip[2]};

    genvar gi;
    generate
        for (gi = 0; gi < TRACE_SLOTS; gi++) begin : g_slot
            assign slot_entry[gi] = make_entry(trace_rv_i_insn_ip[gi*32 +: 32],
                                               trace_rv_i_address_ip[gi*32 +: 32],
                                               trace_rv_i_exception_ip[gi],
                                               trace_rv_i_interrupt_ip[gi],
                                               trace_rv_i_ecause_ip);
`ifdef SWERV_TRACE_FILTER_EN
            // Exceptions and interrupts are always interesting, whatever their PC.
            assign slot_keep[gi] = ((trace_rv_i_address_ip[gi*32 +: 32] >= filt_lo) &&
                                    (trace_rv_i_address_ip[gi*32 +: 32] <= filt_hi)) ||
                                   trace_rv_i_exception_ip[gi] || trace_rv_i_interrupt_ip[gi];
`else
            assign slot_keep[gi] = 1'b1;
`endif
            assign slot_cand[gi] = trace_en && trace_rv_i_valid_ip[gi] && slot_keep[gi];
        end
    endgenerate

    // Free space deliberately ignores a same-cycle pop.
    assign free_slots = CNT_W'(DEPTH) - fifo_count;
    assign n_cand     = {1'b0, slot_cand[0]} + {1'b0, slot_cand[1]};
    assign ovf_sum    = {1'b0, ovf_cnt_reg} + OVF_SUM_W'(n_drop);

    always_comb begin
        n_wr           = 2'd0;
        wr_data0       = slot_cand[0] ? slot_entry[0] : slot_entry[1];
        ovf_cnt_next   = ovf_cnt_reg;
        lost_pend_next = lost_pend_reg;

        if (free_slots >= CNT_W'(2)) begin
            n_wr = n_cand;
        end else if (free_slots == CNT_W'(1)) begin
            n_wr = (n_cand != 2'd0) ? 2'd1 : 2'd0;
        end
        // Slots are kept in order, so any excess is always the later slot.
        n_drop = n_cand - n_wr;

        // Only a loss from an earlier cycle marks the first entry written now.
        wr_data0.lost = lost_pend_reg;
        if (n_drop != 2'd0) begin
            lost_pend_next = 1'b1;
        end else if (n_wr != 2'd0) begin
            lost_pend_next = 1'b0;
        end

        if (n_drop != 2'd0) begin
            if (ovf_clr) begin
                ovf_cnt_next = OVF_W'(n_drop);
            end else if (ovf_sum[OVF_W]) begin
                ovf_cnt_next = '1;
            end else begin
                ovf_cnt_next = ovf_sum[OVF_W-1:0];
            end
        end else if (ovf_clr) begin
            ovf_cnt_next = '0;
        end
    end

    assign wr_en0 = (n_wr != 2'd0);
    assign wr_en1 = (n_wr == 2'd2);

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            lost_pend_reg <= 1'b0;
            ovf_cnt_reg   <= '0;
        end else begin
            lost_pend_reg <= lost_pend_next;
            ovf_cnt_reg   <= ovf_cnt_next;
        end
    end

    swerv_trace_fifo2w1r #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_l    (rst_l),
        .wr_en0   (wr_en0),
        .wr_data0 (wr_data0),
        .wr_en1   (wr_en1),
        .wr_data1 (slot_entry[1]),
        .rd_en    (pop),
        .rd_data  (rd_data),
        .count    (fifo_count)
    );

    // Head is read straight from registered storage; zeroed while empty.
    assign tr.tr_valid  = (fifo_count != '0);
    assign pop          = tr.tr_valid && tr.tr_ready;
    assign head         = tr.tr_valid ? rd_data : '0;
    assign tr.tr_insn   = head.insn;
    assign tr.tr_addr   = head.addr;
    assign tr.tr_exc    = head.exc;
    assign tr.tr_intr   = head.intr;
    assign tr.tr_ecause = head.ecause;
    assign tr.tr_lost   = head.lost;

    assign level   = fifo_count;
    assign ovf_cnt = ovf_cnt_reg;

endmodule

// File: tb/tb_swerv_trace_capture.sv
// Self-checking bench for swerv_trace_capture: queue-based reference model compared every cycle,
// plus directed literal checks. Build with SWERV_TRACE_FILTER_EN to exercise the filter.
module tb_swerv_trace_capture;
    import swerv_trace_pkg::*;

    localparam int DEPTH   = 16;
    localparam int OVF_W   = 4;
    localparam int CNT_W   = 5;
    localparam int OVF_MAX = 15;

    logic              clk = 1'b0;
    logic              rst_l;
    logic              trace_en;
    logic [63:0]       s_insn;
    logic [63:0]       s_addr;
    logic [2:0]        s_valid;
    logic [2:0]        s_exc;
    logic [2:0]        s_intr;
    logic [4:0]        s_ecause;
    logic              ready;
    logic              ovf_clr;
    logic [OVF_W-1:0]  ovf_cnt;
    logic [CNT_W-1:0]  level;
`ifdef SWERV_TRACE_FILTER_EN
    logic [31:0]       filt_lo;
    logic [31:0]       filt_hi;
`endif

    int checks   = 0;
    int failures = 0;

    trace_entry_t mq[$];
    int           m_ovf  = 0;
    bit           m_pend = 1'b0;

    always #5 clk = ~clk;

    swerv_trace_capture_if tr_if ();
    assign tr_if.tr_ready = ready;

    swerv_trace_capture #(
        .DEPTH (DEPTH),
        .OVF_W (OVF_W)
    ) dut (
        .clk                     (clk),
        .rst_l                   (rst_l),
        .trace_en                (trace_en),
        .trace_rv_i_insn_ip      (s_insn),
        .trace_rv_i_address_ip   (s_addr),
        .trace_rv_i_valid_ip     (s_valid),
        .trace_rv_i_exception_ip (s_exc),
        .trace_rv_i_interrupt_ip (s_intr),
        .trace_rv_i_ecause_ip    (s_ecause),
`ifdef SWERV_TRACE_FILTER_EN
        .filt_lo                 (filt_lo),
        .filt_hi                 (filt_hi),
`endif
        .tr                      (tr_if),
        .ovf_cnt                 (ovf_cnt),
        .ovf_clr                 (ovf_clr),
        .level                   (level)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit keep_slot(input int s);
`ifdef SWERV_TRACE_FILTER_EN
        logic [31:0] a;
        a = s_addr[s*32 +: 32];
        return ((a >= filt_lo) && (a <= filt_hi)) || s_exc[s] || s_intr[s];
`else
        return 1'b1;
`endif
    endfunction

    // Reference model: an ordered queue of entries with room for DEPTH.
    task automatic model_step();
        trace_entry_t cands[$];
        trace_entry_t e;
        int sz, room, nw, nd;
        bit do_pop;
        sz     = mq.size();
        do_pop = (sz > 0) && ready;
        room   = DEPTH - sz;
        nw     = 0;
        nd     = 0;
        for (int s = 0; s < 2; s++) begin
            if (trace_en && s_valid[s] && keep_slot(s)) begin
                e.insn   = s_insn[s*32 +: 32];
                e.addr   = s_addr[s*32 +: 32];
                e.exc    = s_exc[s];
                e.intr   = s_intr[s];
                e.ecause = (s_exc[s] || s_intr[s]) ? s_ecause : 5'd0;
                e.lost   = 1'b0;
                cands.push_back(e);
            end
        end
        if (do_pop) void'(mq.pop_front());
        for (int i = 0; i < cands.size(); i++) begin
            if (i < room) begin
                e      = cands[i];
                e.lost = (nw == 0) && m_pend;
                mq.push_back(e);
                nw++;
            end else begin
                nd++;
            end
        end
        if (nd > 0) m_ovf = ovf_clr ? nd : ((m_ovf + nd > OVF_MAX) ? OVF_MAX : m_ovf + nd);
        else if (ovf_clr) m_ovf = 0;
        if (nd > 0) m_pend = 1'b1;
        else if (nw > 0) m_pend = 1'b0;
    endtask

    always @(posedge clk) begin
        if (!rst_l) begin
            mq.delete();
            m_ovf  = 0;
            m_pend = 1'b0;
        end else begin
            model_step();
        end
    end

    always @(posedge clk) begin
        trace_entry_t h;
        #1;
        h = (mq.size() != 0) ? mq[0] : '0;
        check("tr_valid",  tr_if.tr_valid,  mq.size() != 0);
        check("tr_insn",   tr_if.tr_insn,   h.insn);
        check("tr_addr",   tr_if.tr_addr,   h.addr);
        check("tr_exc",    tr_if.tr_exc,    h.exc);
        check("tr_intr",   tr_if.tr_intr,   h.intr);
        check("tr_ecause", tr_if.tr_ecause, h.ecause);
        check("tr_lost",   tr_if.tr_lost,   h.lost);
        check("level",     level,           mq.size());
        check("ovf_cnt",   ovf_cnt,         m_ovf);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        trace_en = 1'b1;
        s_valid  = '0;
        s_exc    = '0;
        s_intr   = '0;
        s_ecause = '0;
        ovf_clr  = 1'b0;
        s_insn   = '0;
        s_addr   = '0;
    endtask

    task automatic slot(input int s, input logic [31:0] insn, input logic [31:0] addr);
        s_insn[s*32 +: 32] = insn;
        s_addr[s*32 +: 32] = addr;
        s_valid[s]         = 1'b1;
    endtask

    task automatic dual(input int k);
        slot(0, 32'h1000 + 32'(2*k), 32'h6000 + 32'(8*k));
        slot(1, 32'h1001 + 32'(2*k), 32'h6004 + 32'(8*k));
    endtask

    initial begin
        rst_l = 1'b0;
        ready = 1'b0;
        idle();
`ifdef SWERV_TRACE_FILTER_EN
        filt_lo = 32'h0;
        filt_hi = 32'hFFFF_FFFF;
`endif
        tick();
        tick();
        check("rst_valid", tr_if.tr_valid, 0);
        check("rst_level", level, 0);
        check("rst_ovf", ovf_cnt, 0);
        check("rst_insn", tr_if.tr_insn, 0);
        rst_l = 1'b1;

        slot(0, 32'h0000_0013, 32'h8000_0000);
        tick();
        idle();
        check("single_valid", tr_if.tr_valid, 1);
        check("single_insn", tr_if.tr_insn, 32'h0000_0013);
        check("single_addr", tr_if.tr_addr, 32'h8000_0000);
        check("single_level", level, 1);
        check("single_ovf", ovf_cnt, 0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("single_drained", level, 0);

        for (int k = 0; k < 10; k++) begin
            slot(0, 32'h100 + 32'(2*k), 32'h2000 + 32'(8*k));
            slot(1, 32'h101 + 32'(2*k), 32'h2004 + 32'(8*k));
            tick();
        end
        idle();
        check("burst_level", level, 16);
        check("burst_ovf", ovf_cnt, 4);
        check("burst_head", tr_if.tr_insn, 32'h100);

        ready = 1'b1;
        slot(0, 32'hDEAD, 32'h4000);
        tick();
        idle();
        ready = 1'b0;
        check("fullpop_level", level, 15);
        check("fullpop_ovf", ovf_cnt, 5);
        check("fullpop_head", tr_if.tr_insn, 32'h101);

        slot(0, 32'hABC, 32'h4004);
        tick();
        idle();
        check("refill_level", level, 16);
        ready = 1'b1;
        repeat (15) tick();
        check("lost_insn", tr_if.tr_insn, 32'hABC);
        check("lost_flag", tr_if.tr_lost, 1);
        tick();
        ready = 1'b0;
        check("lost_drained", level, 0);

        slot(0, 32'h11, 32'h3000);
        slot(1, 32'h22, 32'h3004);
        s_exc    = 3'b010;
        s_ecause = 5'd2;
        tick();
        idle();
        check("exc_s0_insn", tr_if.tr_insn, 32'h11);
        check("exc_s0_ecause", tr_if.tr_ecause, 0);
        ready = 1'b1;
        tick();
        check("exc_s1_insn", tr_if.tr_insn, 32'h22);
        check("exc_s1_exc", tr_if.tr_exc, 1);
        check("exc_s1_ecause", tr_if.tr_ecause, 2);
        tick();
        ready = 1'b0;

        trace_en = 1'b0;
        slot(0, 32'h33, 32'h3008);
        slot(1, 32'h34, 32'h300C);
        tick();
        idle();
        check("disabled_level", level, 0);
        slot(0, 32'h44, 32'h3010);
        s_intr   = 3'b001;
        s_ecause = 5'd7;
        tick();
        idle();
        check("intr_flag", tr_if.tr_intr, 1);
        check("intr_ecause", tr_if.tr_ecause, 7);
        ready = 1'b1;
        tick();
        ready = 1'b0;

        for (int k = 0; k < 14; k++) begin
            dual(k);
            tick();
        end
        idle();
        check("sat_ovf", ovf_cnt, OVF_MAX);
        slot(0, 32'h77, 32'h7000);
        tick();
        idle();
        check("sat_hold", ovf_cnt, OVF_MAX);
        dual(20);
        ovf_clr = 1'b1;
        tick();
        idle();
        check("clr_with_drops", ovf_cnt, 2);
        ovf_clr = 1'b1;
        tick();
        idle();
        check("clr_alone", ovf_cnt, 0);

        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        check("midrst_level", level, 0);
        check("midrst_valid", tr_if.tr_valid, 0);
        slot(0, 32'h88, 32'h8000);
        tick();
        idle();
        check("postrst_lost", tr_if.tr_lost, 0);
        check("postrst_level", level, 1);
        ready = 1'b1;
        tick();
        ready = 1'b0;

`ifdef SWERV_TRACE_FILTER_EN
        filt_lo = 32'h1000;
        filt_hi = 32'h1FFF;
        slot(0, 32'h55, 32'h0800);
        slot(1, 32'h66, 32'h1004);
        tick();
        idle();
        check("filt_level", level, 1);
        check("filt_insn", tr_if.tr_insn, 32'h66);
        check("filt_ovf", ovf_cnt, 0);
        slot(0, 32'h99, 32'h9000);
        s_exc    = 3'b001;
        s_ecause = 5'd3;
        tick();
        idle();
        check("filt_exc_level", level, 2);
`endif

        ready = 1'b1;
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
